// File: rtl/if_id_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_id_fetch_stage
// Description : Instruction-fetch PC plus IF/ID pipeline register, with
//               ID-resolved redirects (j/jal, jr, taken beq), stall and flush.
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_fetch_stage #(
   parameter logic [31:0] PC_RESET  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   output logic [31:0] imem_addr_o,
   input  logic [31:0] imem_data_i,
   input  logic        stall_i,
   input  logic        flush_i,
   input  logic [1:0]  jump_sel_i,
   input  logic        branch_taken_i,
   input  logic [31:0] rs_data_i,
   output logic [31:0] pc_o,
   output logic [31:0] id_instr_o,
   output logic [31:0] id_pc_plus4_o,
   output logic        id_valid_o,
   output logic [5:0]  instr_op_o,
   output logic [5:0]  funct_o,
   output logic        redirect_o
);

   localparam logic [1:0]  c_JSEL_J  = 2'b00;
   localparam logic [1:0]  c_JSEL_JR = 2'b10;
   localparam logic [31:0] c_FOUR    = 32'd4;

   logic [31:0] r_pc;
   logic [31:0] r_id_instr;
   logic [31:0] r_id_pc4;
   logic        r_id_valid;

   logic [31:0] w_pc_plus4;
   logic [31:0] w_j_target;
   logic [31:0] w_jr_target;
   logic [31:0] w_br_target;
   logic [31:0] w_target;
   logic        w_redirect_cond;
   logic        w_redirect;
   logic        w_unused_rs_lo;

   assign w_pc_plus4  = r_pc + c_FOUR;
   assign w_j_target  = {r_id_pc4[31:28], r_id_instr[25:0], 2'b00};
   assign w_jr_target = {rs_data_i[31:2], 2'b00};
   assign w_br_target = r_id_pc4 + {{14{r_id_instr[15]}}, r_id_instr[15:0], 2'b00};

   // rs low bits are forced to zero in the jr target
   assign w_unused_rs_lo = ^rs_data_i[1:0];

   // Jumps outrank a simultaneous taken branch; bubbles never redirect
   always_comb begin
      w_redirect_cond = 1'b0;
      w_target        = w_pc_plus4;
      if (r_id_valid) begin
         if (jump_sel_i == c_JSEL_J) begin
            w_redirect_cond = 1'b1;
            w_target        = w_j_target;
         end else if (jump_sel_i == c_JSEL_JR) begin
            w_redirect_cond = 1'b1;
            w_target        = w_jr_target;
         end else if (branch_taken_i) begin
            w_redirect_cond = 1'b1;
            w_target        = w_br_target;
         end
      end
   end

   assign w_redirect = w_redirect_cond & ~stall_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_pc       <= PC_RESET;
         r_id_instr <= NOP_INSTR;
         r_id_pc4   <= 32'h0;
         r_id_valid <= 1'b0;
      end else if (stall_i) begin
         r_pc       <= r_pc;
         r_id_instr <= r_id_instr;
         r_id_pc4   <= r_id_pc4;
         r_id_valid <= r_id_valid;
      end else if (w_redirect) begin
         // Squash the wrong-path word fetched this cycle
         r_pc       <= w_target;
         r_id_instr <= NOP_INSTR;
         r_id_pc4   <= 32'h0;
         r_id_valid <= 1'b0;
      end else if (flush_i) begin
         r_pc       <= w_pc_plus4;
         r_id_instr <= NOP_INSTR;
         r_id_pc4   <= 32'h0;
         r_id_valid <= 1'b0;
      end else begin
         r_pc       <= w_pc_plus4;
         r_id_instr <= imem_data_i;
         r_id_pc4   <= w_pc_plus4;
         r_id_valid <= 1'b1;
      end
   end

   assign imem_addr_o   = r_pc;
   assign pc_o          = r_pc;
   assign id_instr_o    = r_id_instr;
   assign id_pc_plus4_o = r_id_pc4;
   assign id_valid_o    = r_id_valid;
   assign instr_op_o    = r_id_instr[31:26];
   assign funct_o       = r_id_instr[5:0];
   assign redirect_o    = w_redirect;

endmodule
`default_nettype wire

// File: tb/tb_if_id_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_id_fetch_stage
// Description : Directed vector bench for the fetch stage and IF/ID register.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_id_fetch_stage;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [31:0] imem_addr_o;
   logic [31:0] imem_data_i;
   logic        stall_i;
   logic        flush_i;
   logic [1:0]  jump_sel_i;
   logic        branch_taken_i;
   logic [31:0] rs_data_i;
   logic [31:0] pc_o;
   logic [31:0] id_instr_o;
   logic [31:0] id_pc_plus4_o;
   logic        id_valid_o;
   logic [5:0]  instr_op_o;
   logic [5:0]  funct_o;
   logic        redirect_o;

   int checks   = 0;
   int failures = 0;

   if_id_fetch_stage #(
      .PC_RESET  (32'h0000_0000),
      .NOP_INSTR (32'h0000_0000)
   ) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .imem_addr_o    (imem_addr_o),
      .imem_data_i    (imem_data_i),
      .stall_i        (stall_i),
      .flush_i        (flush_i),
      .jump_sel_i     (jump_sel_i),
      .branch_taken_i (branch_taken_i),
      .rs_data_i      (rs_data_i),
      .pc_o           (pc_o),
      .id_instr_o     (id_instr_o),
      .id_pc_plus4_o  (id_pc_plus4_o),
      .id_valid_o     (id_valid_o),
      .instr_op_o     (instr_op_o),
      .funct_o        (funct_o),
      .redirect_o     (redirect_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic        stall;
      logic        flush;
      logic [1:0]  js;
      logic        bt;
      logic [31:0] rs;
      logic [31:0] imem;
      logic        exp_redir;
      logic [31:0] exp_pc;
      logic [31:0] exp_instr;
      logic [31:0] exp_pc4;
      logic        exp_valid;
   } vec_t;

   localparam int c_NVEC = 26;
   vec_t vecs [c_NVEC];

   function automatic vec_t mk(input logic st, input logic fl, input logic [1:0] js,
                               input logic bt, input logic [31:0] rs, input logic [31:0] im,
                               input logic rd, input logic [31:0] pc, input logic [31:0] ins,
                               input logic [31:0] p4, input logic v);
      vec_t t;
      t.stall = st; t.flush = fl; t.js = js; t.bt = bt; t.rs = rs; t.imem = im;
      t.exp_redir = rd; t.exp_pc = pc; t.exp_instr = ins; t.exp_pc4 = p4; t.exp_valid = v;
      return t;
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s step=%0d got=%h want=%h", name, idx, act, exp);
      end
   endtask

   task automatic chk_state(input int idx, input logic [31:0] pc, input logic [31:0] ins,
                            input logic [31:0] p4, input logic v);
      chk("pc",        idx, pc_o,          pc);
      chk("imem_addr", idx, imem_addr_o,   pc);
      chk("id_instr",  idx, id_instr_o,    ins);
      chk("id_pc4",    idx, id_pc_plus4_o, p4);
      chk("id_valid",  idx, {31'h0, id_valid_o}, {31'h0, v});
      chk("instr_op",  idx, {26'h0, instr_op_o}, {26'h0, ins[31:26]});
      chk("funct",     idx, {26'h0, funct_o},    {26'h0, ins[5:0]});
   endtask

   task automatic drive(input logic st, input logic fl, input logic [1:0] js,
                        input logic bt, input logic [31:0] rs, input logic [31:0] im);
      stall_i = st; flush_i = fl; jump_sel_i = js; branch_taken_i = bt;
      rs_data_i = rs; imem_data_i = im;
   endtask

   initial begin
      //                st    fl    js     bt    rs            imem          rd    pc            instr         pc4           v
      vecs[0]  = mk(1'b0, 1'b0, 2'b00, 1'b0, 32'h0,        32'hA000_0000, 1'b0, 32'h0000_0004, 32'hA000_0000, 32'h0000_0004, 1'b1);
      vecs[1]  = mk(1'b0, 1'b0, 2'b01, 1'b0, 32'h0,        32'hA000_0004, 1'b0, 32'h0000_0008, 32'hA000_0004, 32'h0000_0008, 1'b1);
      vecs[2]  = mk(1'b0, 1'b0, 2'b01, 1'b0, 32'h0,        32'hA000_0008, 1'b0, 32'h0000_000C, 32'hA000_0008, 32'h0000_000C, 1'b1);
      vecs[3]  = mk(1'b0, 1'b0, 2'b11, 1'b0, 32'h0,        32'hA000_000C, 1'b0, 32'h0000_0010, 32'hA000_000C, 32'h0000_0010, 1'b1);
      vecs[4]  = mk(1'b0, 1'b0, 2'b10, 1'b0, 32'h1000_0005, 32'hA000_0010, 1'b1, 32'h1000_0004, 32'h0,        32'h0,         1'b0);
      vecs[5]  = mk(1'b0, 1'b0, 2'b00, 1'b0, 32'h0,        32'h0800_0040, 1'b0, 32'h1000_0008, 32'h0800_0040, 32'h1000_0008, 1'b1);
      vecs[6]  = mk(1'b0, 1'b0, 2'b00, 1'b0, 32'h0,        32'hDEAD_BEEF, 1'b1, 32'h1000_0100, 32'h0,        32'h0,         1'b0);
      vecs[7]  = mk(1'b0, 1'b0, 2'b00, 1'b0, 32'h0,        32'h0000_0008, 1'b0, 32'h1000_0104, 32'h0000_0008, 32'h1000_0104, 1'b1);
      vecs[8]  = mk(1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_001F, 32'hDEAD_BEEF, 1'b1, 32'h0000_001C, 32'h0,        32'h0,         1'b0);
      vecs[9]  = mk(1'b0, 1'b0, 2'b01, 1'b0, 32'h0,        32'h1000_FFFE, 1'b0, 32'h0000_0020, 32'h1000_FFFE, 32'h0000_0020, 1'b1);
      vecs[10] = mk(1'b0, 1'b0, 2'b01, 1'b1, 32'h0,        32'hDEAD_BEEF, 1'b1, 32'h0000_0018, 32'h0,        32'h0,         1'b0);
      vecs[11] = mk(1'b0, 1'b0, 2'b01, 1'b0, 32'h0,        32'h1000_FFFE, 1'b0, 32'h0000_001C, 32'h1000_FFFE, 32'h0000_001C, 1'b1);
      vecs[12] = mk(1'b0, 1'b0, 2'b01, 1'b0, 32'h0,        32'hA000_001C, 1'b0, 32'h0000_0020, 32'hA000_001C, 32'h0000_0020, 1'b1);
      // jump wins over taken branch: j target 0x70, branch would give 0x90
      vecs[13] = mk(1'b0, 1'b0, 2'b00, 1'b1, 32'h0,        32'hDEAD_BEEF, 1'b1, 32'h0000_0070, 32'h0,        32'h0,         1'b0);
      vecs[14] = mk(1'b0, 1'b0, 2'b01, 1'b0, 32'h0,        32'h0000_0008, 1'b0, 32'h0000_0074, 32'h0000_0008, 32'h0000_0074, 1'b1);
      vecs[15] = mk(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0047, 32'hDEAD_BEEF, 1'b0, 32'h0000_0074, 32'h0000_0008, 32'h0000_0074, 1'b1);
      vecs[16] = mk(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0047, 32'hDEAD_BEEF, 1'b0, 32'h0000_0074, 32'h0000_0008, 32'h0000_0074, 1'b1);
      vecs[17] = mk(1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_0047, 32'hDEAD_BEEF, 1'b1, 32'h0000_0044, 32'h0,        32'h0,         1'b0);
      vecs[18] = mk(1'b0, 1'b0, 2'b01, 1'b0, 32'h0,        32'h0000_0008, 1'b0, 32'h0000_0048, 32'h0000_0008, 32'h0000_0048, 1'b1);
      vecs[19] = mk(1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_0030, 32'hDEAD_BEEF, 1'b1, 32'h0000_0030, 32'h0,        32'h0,         1'b0);
      vecs[20] = mk(1'b0, 1'b1, 2'b01, 1'b0, 32'h0,        32'hA000_0030, 1'b0, 32'h0000_0034, 32'h0,        32'h0,         1'b0);
      vecs[21] = mk(1'b0, 1'b0, 2'b01, 1'b0, 32'h0,        32'hA000_0034, 1'b0, 32'h0000_0038, 32'hA000_0034, 32'h0000_0038, 1'b1);
      vecs[22] = mk(1'b1, 1'b1, 2'b00, 1'b0, 32'h0,        32'hDEAD_BEEF, 1'b0, 32'h0000_0038, 32'hA000_0034, 32'h0000_0038, 1'b1);
      vecs[23] = mk(1'b0, 1'b0, 2'b10, 1'b0, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 1'b1, 32'hFFFF_FFFC, 32'h0,        32'h0,         1'b0);
      vecs[24] = mk(1'b0, 1'b0, 2'b01, 1'b0, 32'h0,        32'hA000_00FC, 1'b0, 32'h0000_0000, 32'hA000_00FC, 32'h0000_0000, 1'b1);
      vecs[25] = mk(1'b0, 1'b0, 2'b01, 1'b0, 32'h0,        32'hA000_0000, 1'b0, 32'h0000_0004, 32'hA000_0000, 32'h0000_0004, 1'b1);

      rst_i = 1'b1;
      drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'hDEAD_BEEF);
      @(posedge clk_i); #1;
      chk_state(-1, 32'h0, 32'h0, 32'h0, 1'b0);
      #3;
      chk("redirect", -1, {31'h0, redirect_o}, 32'h0);
      rst_i = 1'b0;

      for (int i = 0; i < c_NVEC; i++) begin
         drive(vecs[i].stall, vecs[i].flush, vecs[i].js, vecs[i].bt, vecs[i].rs, vecs[i].imem);
         #3;
         chk("redirect", i, {31'h0, redirect_o}, {31'h0, vecs[i].exp_redir});
         @(posedge clk_i); #1;
         chk_state(i, vecs[i].exp_pc, vecs[i].exp_instr, vecs[i].exp_pc4, vecs[i].exp_valid);
      end

      // Reset landing on a redirect cycle: target 0x100 must be discarded
      drive(1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF);
      #3;
      chk("redirect", 100, {31'h0, redirect_o}, 32'h1);
      rst_i = 1'b1;
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      chk_state(100, 32'h0, 32'h0, 32'h0, 1'b0);

      // Fetch resumes at reset PC, then reset while stalled
      drive(1'b0, 1'b0, 2'b01, 1'b0, 32'h0, 32'hA000_0000);
      @(posedge clk_i); #1;
      chk_state(101, 32'h4, 32'hA000_0000, 32'h4, 1'b1);
      drive(1'b1, 1'b0, 2'b01, 1'b0, 32'h0, 32'hA000_0004);
      rst_i = 1'b1;
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      chk_state(102, 32'h0, 32'h0, 32'h0, 1'b0);
      drive(1'b0, 1'b0, 2'b01, 1'b0, 32'h0, 32'hA000_0000);
      @(posedge clk_i); #1;
      chk_state(103, 32'h4, 32'hA000_0000, 32'h4, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout checks=%0d", checks);
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
